// File: rtl/bsr_pkg.sv
// Shared types for the streaming bit reader: command opcodes, FSM states,
// the maximum fixed-length read width and the se(v) mapping helper.
package bsr_pkg;

  localparam int MAX_N = 32;

  typedef enum logic [2:0] {
    OP_U     = 3'd0,
    OP_UE    = 3'd1,
    OP_SE    = 3'd2,
    OP_ALIGN = 3'd3,
    OP_PEEK  = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COUNT,
    RESP
  } state_t;

  // Exp-Golomb code number to signed value: odd k -> positive, even k -> negative.
  function automatic logic [31:0] se_map(input logic [31:0] k);
    if (k[0]) begin
      return (k + 32'd1) >> 1;
    end
    return 32'd0 - (k >> 1);
  endfunction

endpackage

// File: rtl/bitstream_reader_stream_if.sv
// Word-stream input, command and response handshakes of the bit reader.
// master = producer/parser side, slave = the reader itself.
interface bitstream_reader_stream_if #(
  parameter int IN_W = 32
) ();
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic            cmd_valid;
  logic [2:0]      cmd_op;
  logic [5:0]      cmd_n;
  logic            cmd_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_value;
  logic            rsp_error;

  modport master (
    output in_data, in_valid, in_last, cmd_valid, cmd_op, cmd_n, rsp_ready,
    input  in_ready, cmd_ready, rsp_valid, rsp_value, rsp_error
  );

  modport slave (
    input  in_data, in_valid, in_last, cmd_valid, cmd_op, cmd_n, rsp_ready,
    output in_ready, cmd_ready, rsp_valid, rsp_value, rsp_error
  );
endinterface

// File: rtl/bsr_clz32.sv
// Combinational 32-bit leading-zero count; returns 32 for an all-zero word.
module bsr_clz32 (
  input  logic [31:0] x,
  output logic [5:0]  lz
);
  always_comb begin
    lz = 6'd32;
    // Scanning upwards so the highest set bit is the last one to win.
    for (int unsigned i = 0; i < 32; i++) begin
      if (x[i]) lz = 6'(31 - i);
    end
  end
endmodule

// File: rtl/bitstream_reader_stream.sv
// Streaming MSB-first bit reader serving u(n)/ue(v)/se(v)/align commands.
// Optional BSR_PEEK_EN enables op 4 (non-consuming read of n bits).
module bitstream_reader_stream
  import bsr_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int BUF_W = 128
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  bitstream_reader_stream_if.slave      bus,
  output logic [31:0]                   bits_consumed,
  output logic                          busy
);
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int PAD_W = BUF_W - IN_W;

  // Buffered bits sit left-aligned; everything below fill is kept zero.
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             eos_q, eos_d;
  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [5:0]       n_q, n_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_value_q, rsp_value_d;
  logic             rsp_error_q, rsp_error_d;
  logic [31:0]      bc_q, bc_d;

  logic [31:0]      top32;
  logic [63:0]      top64;
  logic [5:0]       lz;
  logic [6:0]       cw_len;
  logic [63:0]      codeword;
  logic [31:0]      k;
  logic [2:0]       align_n;
  logic             n_ok;
  logic             legal;
  logic [6:0]       consume;
  logic [CNT_W-1:0] fill_c;
  logic [BUF_W-1:0] buf_sh;
  logic             in_fire;

  assign top32    = buf_q[BUF_W-1 -: 32];
  assign top64    = buf_q[BUF_W-1 -: 64];
  assign cw_len   = {lz, 1'b1};
  // Whole codeword read as an integer is 2^lz + suffix, so k is that minus one.
  assign codeword = top64 >> (7'd64 - cw_len);
  assign k        = 32'(codeword - 64'd1);
  assign align_n  = 3'd0 - bc_q[2:0];
  assign n_ok     = (bus.cmd_n != 6'd0) && (bus.cmd_n <= 6'(MAX_N));

  bsr_clz32 u_clz (
    .x  (top32),
    .lz (lz)
  );

  assign bus.in_ready  = (fill_q <= CNT_W'(PAD_W)) && !eos_q;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_value = rsp_value_q;
  assign bus.rsp_error = rsp_error_q;
  assign bits_consumed = bc_q;
  assign busy          = (state_q != IDLE);
  assign in_fire       = bus.in_valid && bus.in_ready;

  always_comb begin
    legal = 1'b0;
    case (bus.cmd_op)
      OP_U:                     legal = n_ok;
      OP_UE, OP_SE, OP_ALIGN:   legal = 1'b1;
`ifdef BSR_PEEK_EN
      OP_PEEK:                  legal = n_ok;
`endif
      default:                  legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    n_d         = n_q;
    rsp_valid_d = rsp_valid_q;
    rsp_value_d = rsp_value_q;
    rsp_error_d = rsp_error_q;
    consume     = 7'd0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d = op_t'(bus.cmd_op);
          n_d  = bus.cmd_n;
          if (legal) begin
            state_d = WAIT;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_value_d = '0;
            rsp_error_d = 1'b1;
          end
        end
      end
      WAIT: begin
        case (op_q)
`ifdef BSR_PEEK_EN
          OP_U, OP_PEEK: begin
`else
          OP_U: begin
`endif
            if (fill_q >= CNT_W'(n_q)) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_value_d = top32 >> (6'd32 - n_q);
              rsp_error_d = 1'b0;
              if (op_q == OP_U) consume = 7'(n_q);
            end else if (eos_q) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_value_d = '0;
              rsp_error_d = 1'b1;
            end
          end
          OP_UE, OP_SE: begin
            if (fill_q >= CNT_W'(32) || eos_q) state_d = COUNT;
          end
          OP_ALIGN: begin
            if (fill_q >= CNT_W'(align_n)) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_value_d = 32'(align_n);
              rsp_error_d = 1'b0;
              consume     = 7'(align_n);
            end else if (eos_q) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_value_d = '0;
              rsp_error_d = 1'b1;
            end
          end
          default: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_value_d = '0;
            rsp_error_d = 1'b1;
          end
        endcase
      end
      COUNT: begin
        // A long codeword without eos just waits here for the rest of its bits.
        if (lz[5] || (CNT_W'(cw_len) > fill_q && eos_q)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_value_d = '0;
          rsp_error_d = 1'b1;
        end else if (CNT_W'(cw_len) <= fill_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_value_d = (op_q == OP_SE) ? se_map(k) : k;
          rsp_error_d = 1'b0;
          consume     = cw_len;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_sh = buf_q << consume;
    fill_c = fill_q - CNT_W'(consume);
    buf_d  = buf_sh;
    fill_d = fill_c;
    eos_d  = eos_q;
    bc_d   = bc_q + 32'(consume);
    if (in_fire) begin
      buf_d  = buf_sh | ({bus.in_data, {PAD_W{1'b0}}} >> fill_c);
      fill_d = fill_c + CNT_W'(IN_W);
      eos_d  = eos_q | bus.in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      buf_q       <= '0;
      fill_q      <= '0;
      eos_q       <= 1'b0;
      state_q     <= IDLE;
      op_q        <= OP_U;
      n_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_value_q <= '0;
      rsp_error_q <= 1'b0;
      bc_q        <= '0;
    end else begin
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      eos_q       <= eos_d;
      state_q     <= state_d;
      op_q        <= op_d;
      n_q         <= n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_value_q <= rsp_value_d;
      rsp_error_q <= rsp_error_d;
      bc_q        <= bc_d;
    end
  end

endmodule

// File: tb/tb_bitstream_reader_stream.sv
// Directed bench for bitstream_reader_stream: command table over a preloaded
// stream plus hand-written stall, backpressure, flush and peek sequences.
module tb_bitstream_reader_stream;
  import bsr_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] bits_consumed;
  logic        busy;

  bitstream_reader_stream_if #(.IN_W(32)) bus ();

  bitstream_reader_stream #(.IN_W(32), .BUF_W(128)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .bus           (bus),
    .bits_consumed (bits_consumed),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  n;
    logic [31:0] val;
    logic        err;
    logic [31:0] bc;
    int          lat;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input logic last);
    int t;
    @(negedge clk);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout_fail("push_word");
    else @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] n);
    int t;
    @(negedge clk);
    t = 0;
    while (!bus.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout_fail("cmd_ready");
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_n     = n;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [5:0] n,
                         output logic [31:0] val, output logic err, output int lat);
    issue(op, n);
    lat = 1;
    while (!bus.rsp_valid) begin
      if (lat >= 200) break;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.rsp_valid) begin
      timeout_fail("rsp_valid");
      val = 'x;
      err = 1'bx;
    end else begin
      val = bus.rsp_value;
      err = bus.rsp_error;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] val;
    logic        err;
    int          lat;
    logic        seen;
    int          t;
    logic [31:0] held;

    // op, n, value, error, bits_consumed after, accept-to-rsp_valid cycles
    vecs[0]  = '{3'd0, 6'd4,  32'h0000000A, 1'b0, 32'd4,   2};
    vecs[1]  = '{3'd0, 6'd4,  32'h00000005, 1'b0, 32'd8,   2};
    vecs[2]  = '{3'd1, 6'd0,  32'd6,        1'b0, 32'd13,  3};
    vecs[3]  = '{3'd2, 6'd0,  32'hFFFFFFFE, 1'b0, 32'd18,  3};
    vecs[4]  = '{3'd2, 6'd0,  32'd2,        1'b0, 32'd23,  3};
    vecs[5]  = '{3'd1, 6'd0,  32'd0,        1'b0, 32'd24,  3};
    vecs[6]  = '{3'd0, 6'd3,  32'd6,        1'b0, 32'd27,  2};
    vecs[7]  = '{3'd3, 6'd0,  32'd5,        1'b0, 32'd32,  2};
    vecs[8]  = '{3'd3, 6'd0,  32'd0,        1'b0, 32'd32,  2};
    vecs[9]  = '{3'd0, 6'd32, 32'hDEADBEEF, 1'b0, 32'd64,  2};
    vecs[10] = '{3'd2, 6'd0,  32'd0,        1'b0, 32'd65,  3};
    vecs[11] = '{3'd1, 6'd0,  32'd21,       1'b0, 32'd74,  3};
    vecs[12] = '{3'd2, 6'd0,  32'd4,        1'b0, 32'd81,  3};
    vecs[13] = '{3'd0, 6'd15, 32'h00005555, 1'b0, 32'd96,  2};
    vecs[14] = '{3'd0, 6'd8,  32'h00000012, 1'b0, 32'd104, 2};
    vecs[15] = '{3'd5, 6'd8,  32'd0,        1'b1, 32'd104, 1};
    vecs[16] = '{3'd0, 6'd0,  32'd0,        1'b1, 32'd104, 1};
    vecs[17] = '{3'd0, 6'd33, 32'd0,        1'b1, 32'd104, 1};
    vecs[18] = '{3'd0, 6'd24, 32'h00345678, 1'b0, 32'd128, 2};
    vecs[19] = '{3'd0, 6'd1,  32'd0,        1'b1, 32'd128, 2};
    vecs[20] = '{3'd1, 6'd0,  32'd0,        1'b1, 32'd128, 3};
    vecs[21] = '{3'd3, 6'd0,  32'd0,        1'b0, 32'd128, 2};

    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_n     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_bc", bits_consumed, 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_value", bus.rsp_value, 32'd0);
    chk("reset_rsp_error", 32'(bus.rsp_error), 32'd0);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b0;

    // Word layout chosen so the table walks through every command type.
    push_word(32'hA53949D5, 1'b0);
    push_word(32'hDEADBEEF, 1'b0);
    push_word(32'h85845555, 1'b0);
    push_word(32'h12345678, 1'b1);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);

    for (int i = 0; i < 22; i++) begin
      run_cmd(vecs[i].op, vecs[i].n, val, err, lat);
      chk($sformatf("vec%0d_value", i), val, vecs[i].val);
      chk($sformatf("vec%0d_error", i), 32'(err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_bc", i), bits_consumed, vecs[i].bc);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Short final stream: a read past the end errors and consumes nothing.
    pulse_flush();
    chk("flush_bc", bits_consumed, 32'd0);
    push_word(32'hCAFEF00D, 1'b1);
    chk("eos_in_ready", 32'(bus.in_ready), 32'd0);
    run_cmd(3'd0, 6'd32, val, err, lat);
    chk("eos_u32_value", val, 32'hCAFEF00D);
    chk("eos_u32_error", 32'(err), 32'd0);
    run_cmd(3'd0, 6'd16, val, err, lat);
    chk("eos_u16_error", 32'(err), 32'd1);
    chk("eos_u16_value", val, 32'd0);
    chk("eos_u16_bc", bits_consumed, 32'd32);

    // Command waits on an empty buffer, then the response is backpressured.
    pulse_flush();
    issue(3'd0, 6'd32);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("stall_no_rsp", 32'(seen), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    push_word(32'h13579BDF, 1'b0);
    t = 0;
    while (!bus.rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rsp_valid) timeout_fail("stall_rsp");
    chk("stall_value", bus.rsp_value, 32'h13579BDF);
    held = bus.rsp_value;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_value", i), bus.rsp_value, held);
      chk($sformatf("hold%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("hold%0d_cmd_ready", i), 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("hold_done_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("hold_done_bc", bits_consumed, 32'd32);

    // Flush while a command waits: no response appears, buffer is emptied.
    pulse_flush();
    push_word(32'h0F0F0F0F, 1'b0);
    run_cmd(3'd0, 6'd8, val, err, lat);
    chk("pre_flush_value", val, 32'h0000000F);
    issue(3'd0, 6'd32);
    repeat (3) @(negedge clk);
    chk("pre_flush_busy", 32'(busy), 32'd1);
    pulse_flush();
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("flush_no_rsp", 32'(seen), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("flush_bc2", bits_consumed, 32'd0);
    push_word(32'h5AC30000, 1'b0);
    run_cmd(3'd4, 6'd8, val, err, lat);
`ifdef BSR_PEEK_EN
    chk("peek1_value", val, 32'h0000005A);
    chk("peek1_error", 32'(err), 32'd0);
`else
    chk("peek1_value", val, 32'd0);
    chk("peek1_error", 32'(err), 32'd1);
`endif
    run_cmd(3'd4, 6'd8, val, err, lat);
`ifdef BSR_PEEK_EN
    chk("peek2_value", val, 32'h0000005A);
    chk("peek2_error", 32'(err), 32'd0);
`else
    chk("peek2_value", val, 32'd0);
    chk("peek2_error", 32'(err), 32'd1);
`endif
    chk("peek_bc", bits_consumed, 32'd0);
    run_cmd(3'd0, 6'd8, val, err, lat);
    chk("post_flush_value", val, 32'h0000005A);
    chk("post_flush_bc", bits_consumed, 32'd8);
    run_cmd(3'd0, 6'd0, val, err, lat);
    chk("n0_error", 32'(err), 32'd1);
    chk("n0_latency", 32'(lat), 32'd1);
    chk("n0_bc", bits_consumed, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
